control_sequencer: RTL

- Hardwired control unit that sits directly upstream of the bus/datapath block.
- Fetches an instruction, decodes the IR it receives back from the datapath, and drives every per-cycle control strobe for T0..T6.
- Replaces hand-driven strobe sequences in datapath benches.
- Covers register ALU, shift/rotate, immediate, mul/div, neg/not, nop and halt instructions.

---
 rtl/cpu_pkg.sv | 73 +++++++
 rtl/control_sequencer_if.sv | 30 +++
 rtl/reg_select_decode.sv | 18 +
 rtl/control_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control sequencer: opcode values,
// IR field positions, sequencer states and the per-cycle strobe bundle.
package cpu_pkg;

  localparam int OP_W      = 5;
  localparam int FIELD_W   = 4;
  localparam int IR_OP_LSB = 27;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_LSB = 15;

  typedef logic [OP_W-1:0] opcode_t;

  localparam opcode_t OP_ADD  = 5'b00011;
  localparam opcode_t OP_SUB  = 5'b00100;
  localparam opcode_t OP_AND  = 5'b00101;
  localparam opcode_t OP_OR   = 5'b00110;
  localparam opcode_t OP_SHR  = 5'b00111;
  localparam opcode_t OP_SHRA = 5'b01000;
  localparam opcode_t OP_SHL  = 5'b01001;
  localparam opcode_t OP_ROR  = 5'b01010;
  localparam opcode_t OP_ROL  = 5'b01011;
  localparam opcode_t OP_ADDI = 5'b01100;
  localparam opcode_t OP_ANDI = 5'b01101;
  localparam opcode_t OP_ORI  = 5'b01110;
  localparam opcode_t OP_MUL  = 5'b01111;
  localparam opcode_t OP_DIV  = 5'b10000;
  localparam opcode_t OP_NEG  = 5'b10001;
  localparam opcode_t OP_NOT  = 5'b10010;
  localparam opcode_t OP_NOP  = 5'b11001;
  localparam opcode_t OP_HALT = 5'b11010;

  typedef enum logic [3:0] {
    S_FETCH0, S_FETCH1, S_FETCH2, S_EX3, S_EX4, S_EX5, S_EX6, S_PAUSE, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_RTYPE, CLS_IMM, CLS_MULDIV, CLS_UNARY, CLS_NOP, CLS_HALT, CLS_ILLEGAL
  } op_class_t;

  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic pc_in;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic y_in;
    logic zlow_in;
    logic zhigh_in;
    logic zlo_out;
    logic zhi_out;
    logic hi_in;
    logic lo_in;
    logic c_out;
  } strobes_t;

  function automatic op_class_t classify(input opcode_t op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHRA, OP_SHL, OP_ROR, OP_ROL:    return CLS_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI:           return CLS_IMM;
      OP_MUL, OP_DIV:                     return CLS_MULDIV;
      OP_NEG, OP_NOT:                     return CLS_UNARY;
      OP_NOP:                             return CLS_NOP;
      OP_HALT:                            return CLS_HALT;
      default:                            return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath bundle: IR and memory handshake in, control strobes out.
interface control_sequencer_if #(
  parameter int OPW  = 5,
  parameter int NREG = 16
);
  logic [31:0]     ir;
  logic            mem_rdy;
  logic            stop;
  logic            run;
  logic            PCout, MARin, IncPC, PCin, read, MDRin, MDRout, IRin, Yin;
  logic            Zlowin, Zhighin, ZLOout, ZHIout, HIin, LOin, Cout;
  logic [OPW-1:0]  operation;
  logic [NREG-1:0] reg_in;
  logic [NREG-1:0] reg_out;
  logic            illegal;

  modport master (
    input  ir, mem_rdy, stop,
    output run, PCout, MARin, IncPC, PCin, read, MDRin, MDRout, IRin, Yin,
           Zlowin, Zhighin, ZLOout, ZHIout, HIin, LOin, Cout,
           operation, reg_in, reg_out, illegal
  );

  modport slave (
    output ir, mem_rdy, stop,
    input  run, PCout, MARin, IncPC, PCin, read, MDRin, MDRout, IRin, Yin,
           Zlowin, Zhighin, ZLOout, ZHIout, HIin, LOin, Cout,
           operation, reg_in, reg_out, illegal
  );
endinterface

// File: rtl/reg_select_decode.sv
// Register-field decoder: 4-bit register number plus enable to a one-hot
// load/drive vector; all zeros when disabled.
module reg_select_decode
  import cpu_pkg::*;
#(
  parameter int NREG = 16
) (
  input  logic [FIELD_W-1:0] sel,
  input  logic               en,
  output logic [NREG-1:0]    onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer driving the datapath strobes for T0..T6.
// Define ILLEGAL_TRAP_EN to halt on an illegal opcode instead of treating it as nop.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int OPW  = 5,
  parameter int NREG = 16
) (
  input  logic               clock,
  input  logic               clear,
  control_sequencer_if.master bus
);

  state_t             state, next_state, fetch_entry;
  strobes_t           stb, stb_g;
  op_class_t          cls;
  opcode_t            opcode;
  logic [FIELD_W-1:0] ra, rb, rc, rout_sel;
  logic               rin_en, rout_en, drive_op;
  logic [OPW-1:0]     op_q, op_d;
  logic               run_q, illegal_q;
  logic               unused_ir_low;

  assign opcode        = bus.ir[IR_OP_LSB +: OP_W];
  assign ra            = bus.ir[IR_RA_LSB +: FIELD_W];
  assign rb            = bus.ir[IR_RB_LSB +: FIELD_W];
  assign rc            = bus.ir[IR_RC_LSB +: FIELD_W];
  assign unused_ir_low = ^bus.ir[IR_RC_LSB-1:0];
  assign cls           = classify(opcode);

  // Every path back to fetch passes through here so stop is honoured only at FETCH0 entry.
  assign fetch_entry = bus.stop ? S_PAUSE : S_FETCH0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= S_FETCH0;
    else        state <= next_state;
  end

  // NOTE: default assignment first keeps this block purely combinational (no latch).
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH0: next_state = S_FETCH1;
      S_FETCH1: if (bus.mem_rdy) next_state = S_FETCH2;
      S_FETCH2: next_state = S_EX3;
      S_EX3: begin
        case (cls)
          CLS_NOP:     next_state = fetch_entry;
          CLS_HALT:    next_state = S_HALT;
`ifdef ILLEGAL_TRAP_EN
          CLS_ILLEGAL: next_state = S_HALT;
`else
          CLS_ILLEGAL: next_state = fetch_entry;
`endif
          default:     next_state = S_EX4;
        endcase
      end
      S_EX4:   next_state = (cls == CLS_UNARY)  ? fetch_entry : S_EX5;
      S_EX5:   next_state = (cls == CLS_MULDIV) ? S_EX6 : fetch_entry;
      S_EX6:   next_state = fetch_entry;
      S_PAUSE: if (!bus.stop) next_state = S_FETCH0;
      S_HALT:  next_state = S_HALT;
      default: next_state = S_FETCH0;
    endcase
  end

  always_comb begin
    stb      = '0;
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rout_sel = rb;
    drive_op = 1'b0;
    case (state)
      S_FETCH0: begin
        stb.pc_out  = 1'b1;
        stb.mar_in  = 1'b1;
        stb.inc_pc  = 1'b1;
        stb.zlow_in = 1'b1;
      end
      S_FETCH1: begin
        stb.zlo_out = 1'b1;
        stb.read    = 1'b1;
        stb.mdr_in  = 1'b1;
        stb.pc_in   = bus.mem_rdy;
      end
      S_FETCH2: begin
        stb.mdr_out = 1'b1;
        stb.ir_in   = 1'b1;
      end
      S_EX3: begin
        case (cls)
          CLS_RTYPE, CLS_IMM: begin
            rout_en   = 1'b1;
            stb.y_in  = 1'b1;
          end
          CLS_MULDIV: begin
            rout_en   = 1'b1;
            rout_sel  = ra;
            stb.y_in  = 1'b1;
          end
          CLS_UNARY: begin
            rout_en     = 1'b1;
            drive_op    = 1'b1;
            stb.zlow_in = 1'b1;
          end
          default: ;
        endcase
      end
      S_EX4: begin
        case (cls)
          CLS_RTYPE: begin
            rout_en     = 1'b1;
            rout_sel    = rc;
            drive_op    = 1'b1;
            stb.zlow_in = 1'b1;
          end
          CLS_IMM: begin
            stb.c_out   = 1'b1;
            drive_op    = 1'b1;
            stb.zlow_in = 1'b1;
          end
          CLS_MULDIV: begin
            rout_en      = 1'b1;
            drive_op     = 1'b1;
            stb.zlow_in  = 1'b1;
            stb.zhigh_in = 1'b1;
          end
          CLS_UNARY: begin
            stb.zlo_out = 1'b1;
            rin_en      = 1'b1;
          end
          default: ;
        endcase
      end
      S_EX5: begin
        stb.zlo_out = 1'b1;
        if (cls == CLS_MULDIV) stb.lo_in = 1'b1;
        else                   rin_en    = 1'b1;
      end
      S_EX6: begin
        stb.zhi_out = 1'b1;
        stb.hi_in   = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: reset forces state to FETCH0, whose decode is not quiet, so clear masks strobes directly.
  assign stb_g = clear ? stb : '0;
  assign op_d  = drive_op ? OPW'(opcode) : op_q;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      run_q     <= 1'b0;
      illegal_q <= 1'b0;
      op_q      <= '0;
    end else begin
      run_q <= (next_state != S_PAUSE) && (next_state != S_HALT);
      op_q  <= op_d;
      if (state == S_EX3 && cls == CLS_ILLEGAL) illegal_q <= 1'b1;
    end
  end

  reg_select_decode #(.NREG(NREG)) u_reg_in_dec (
    .sel    (ra),
    .en     (rin_en & clear),
    .onehot (bus.reg_in)
  );

  reg_select_decode #(.NREG(NREG)) u_reg_out_dec (
    .sel    (rout_sel),
    .en     (rout_en & clear),
    .onehot (bus.reg_out)
  );

  assign bus.run       = run_q;
  assign bus.illegal   = illegal_q;
  assign bus.operation = op_d;
  assign bus.PCout     = stb_g.pc_out;
  assign bus.MARin     = stb_g.mar_in;
  assign bus.IncPC     = stb_g.inc_pc;
  assign bus.PCin      = stb_g.pc_in;
  assign bus.read      = stb_g.read;
  assign bus.MDRin     = stb_g.mdr_in;
  assign bus.MDRout    = stb_g.mdr_out;
  assign bus.IRin      = stb_g.ir_in;
  assign bus.Yin       = stb_g.y_in;
  assign bus.Zlowin    = stb_g.zlow_in;
  assign bus.Zhighin   = stb_g.zhigh_in;
  assign bus.ZLOout    = stb_g.zlo_out;
  assign bus.ZHIout    = stb_g.zhi_out;
  assign bus.HIin      = stb_g.hi_in;
  assign bus.LOin      = stb_g.lo_in;
  assign bus.Cout      = stb_g.c_out;

endmodule
